md_hilo_ctrl: RTL and testbench

//   Multiply/divide sequencer and HI/LO register owner for the 5-stage pipeline.

---
 rtl/md_hilo_ctrl_if.sv | 22 ++
 rtl/md_hilo_ctrl.sv | 140 ++++++++++++++
 tb/tb_md_hilo_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/md_hilo_ctrl_if.sv
// EX/D-stage connection bundle for the multiply/divide sequencer and its HI/LO outputs.
interface md_hilo_ctrl_if;
  logic        E_start;
  logic [2:0]  E_op;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        D_md_use;
  logic        D_md_stall;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_start, E_op, E_rs, E_rt, D_md_use,
    input  D_md_stall, busy, HI, LO
  );

  modport slave (
    input  E_start, E_op, E_rs, E_rt, D_md_use,
    output D_md_stall, busy, HI, LO
  );
endinterface

// File: rtl/md_hilo_ctrl.sv
// Multiply/divide sequencer: fixed-length busy window per mult/div, owns HI/LO,
// and raises the D-stage stall while a HI/LO consumer would read stale values.
module md_hilo_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset,
  md_hilo_ctrl_if.slave md
);

  localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_count;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_hi_p;
  logic [31:0] r_lo_p;
  logic        r_div0;

  logic        w_md_start;
  logic        w_is_mult;
  logic        w_div0;
  logic [63:0] w_result;

  // Returns {hi, lo}; the single signed-overflow divide case is pinned explicitly.
  function automatic logic [63:0] md_result(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0]        r;
    logic signed [63:0] pa;
    logic signed [63:0] pb;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] rm;
    r  = 64'd0;
    pa = {{32{a[31]}}, a};
    pb = {{32{b[31]}}, b};
    sa = a;
    sb = b;
    q  = 32'sd0;
    rm = 32'sd0;
    case (op)
      3'd1: r = pa * pb;
      3'd2: r = {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) begin
          r = 64'd0;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          r = {32'd0, 32'h8000_0000};
        end else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm, q};
        end
      end
      3'd4: begin
        if (b == 32'd0) begin
          r = 64'd0;
        end else begin
          r = {a % b, a / b};
        end
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Decode of the EX-stage request and its pending result.
  always_comb begin
    w_md_start = md.E_start && (md.E_op >= 3'd1) && (md.E_op <= 3'd4);
    w_is_mult  = (md.E_op == 3'd1) || (md.E_op == 3'd2);
    w_div0     = ((md.E_op == 3'd3) || (md.E_op == 3'd4)) && (md.E_rt == 32'd0);
    w_result   = md_result(md.E_op, md.E_rs, md.E_rt);
  end

  assign md.D_md_stall = md.D_md_use & (r_busy | w_md_start);
  assign md.busy       = r_busy;
  assign md.HI         = r_hi;
  assign md.LO         = r_lo;

  // Sequencer FSM; any E_start seen in RUN (including the commit edge) is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= 4'd0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_hi_p  <= 32'd0;
      r_lo_p  <= 32'd0;
      r_div0  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_md_start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_count <= w_is_mult ? LP_MULT_CNT : LP_DIV_CNT;
            r_hi_p  <= w_result[63:32];
            r_lo_p  <= w_result[31:0];
            r_div0  <= w_div0;
          end else if (md.E_start && (md.E_op == 3'd5)) begin
            r_hi <= md.E_rs;
          end else if (md.E_start && (md.E_op == 3'd6)) begin
            r_lo <= md.E_rs;
          end
        end
        ST_RUN: begin
          if (r_count <= 4'd1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_count <= 4'd0;
            if (!r_div0) begin
              r_hi <= r_hi_p;
              r_lo <= r_lo_p;
            end
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_count <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Self-checking bench for md_hilo_ctrl: directed scenarios plus a randomized run
// against a cycle-level arithmetic model.
module tb_md_hilo_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  md_hilo_ctrl_if u_if();

  md_hilo_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
    .clk  (clk),
    .reset(reset),
    .md   (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Model: remaining busy cycles, committed and pending HI/LO.
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  bit          p_skip = 1'b0;
  logic        obs_stall, exp_stall;

  task automatic model_edge(input bit rst, input bit st, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, rm, prod;
    longint unsigned uprod;
    if (rst) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else if (m_left > 0) begin
      if (m_left == 1 && !p_skip) begin
        m_hi = p_hi; m_lo = p_lo;
      end
      m_left--;
    end else if (st) begin
      case (op)
        3'd1: begin
          prod = longint'($signed(a)) * longint'($signed(b));
          p_hi = prod[63:32]; p_lo = prod[31:0]; p_skip = 1'b0; m_left = MC;
        end
        3'd2: begin
          uprod = longint'({32'd0, a}) * longint'({32'd0, b});
          p_hi = uprod[63:32]; p_lo = uprod[31:0]; p_skip = 1'b0; m_left = MC;
        end
        3'd3: begin
          m_left = DC; p_skip = (b == 32'd0);
          if (b != 32'd0) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = sa / sb; rm = sa % sb;
            p_lo = q[31:0]; p_hi = rm[31:0];
          end
        end
        3'd4: begin
          m_left = DC; p_skip = (b == 32'd0);
          if (b != 32'd0) begin
            p_lo = a / b; p_hi = a % b;
          end
        end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // One clock: drive inputs, sample the combinational stall, take the edge, advance the model.
  task automatic step(input bit rst, input bit st, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input bit use_md);
    reset = rst; u_if.E_start = st; u_if.E_op = op;
    u_if.E_rs = a; u_if.E_rt = b; u_if.D_md_use = use_md;
    #1;
    obs_stall = u_if.D_md_stall;
    exp_stall = use_md && ((m_left > 0) || (st && op >= 3'd1 && op <= 3'd4));
    @(posedge clk);
    model_edge(rst, st, op, a, b);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    n_checks++; if (u_if.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", u_if.busy); end
    n_checks++; if (u_if.HI !== 32'd0) begin n_errors++; $display("FAIL reset_hi: got %h want 0", u_if.HI); end
    n_checks++; if (u_if.LO !== 32'd0) begin n_errors++; $display("FAIL reset_lo: got %h want 0", u_if.LO); end
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    n_checks++; if (obs_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", obs_stall); end
  endtask

  task automatic test_multu();
    for (int i = 0; i <= 6; i++) begin
      step(1'b0, i == 0, 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
      n_checks++; if (obs_stall !== (i <= 5)) begin n_errors++; $display("FAIL multu_stall[%0d]: got %b want %b", i, obs_stall, i <= 5); end
      n_checks++; if (u_if.busy !== (i < 5)) begin n_errors++; $display("FAIL multu_busy[%0d]: got %b want %b", i, u_if.busy, i < 5); end
      if (i >= 5) begin
        n_checks++; if ({u_if.HI, u_if.LO} !== {32'd1, 32'hFFFF_FFFE}) begin n_errors++; $display("FAIL multu_result[%0d]: got %h_%h want 00000001_fffffffe", i, u_if.HI, u_if.LO); end
      end else begin
        n_checks++; if ({u_if.HI, u_if.LO} !== 64'd0) begin n_errors++; $display("FAIL multu_early[%0d]: got %h_%h want 0", i, u_if.HI, u_if.LO); end
      end
    end
  endtask

  task automatic test_mult();
    int nb = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, i == 0, 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
      if (u_if.busy === 1'b1) nb++;
    end
    n_checks++; if (nb != MC) begin n_errors++; $display("FAIL mult_busy_len: got %0d want %0d", nb, MC); end
    n_checks++; if ({u_if.HI, u_if.LO} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin n_errors++; $display("FAIL mult_result: got %h_%h want ffffffff_ffffffeb", u_if.HI, u_if.LO); end
  endtask

  task automatic test_div();
    int nb = 0;
    for (int j = 0; j < 12; j++) begin
      step(1'b0, j == 0, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      if (j == 9) begin
        n_checks++; if (u_if.LO !== 32'hFFFF_FFEB) begin n_errors++; $display("FAIL div_early: got %h want ffffffeb", u_if.LO); end
      end
      if (j == 10) begin
        n_checks++; if ({u_if.HI, u_if.LO} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_errors++; $display("FAIL div_result: got %h_%h want ffffffff_fffffffd", u_if.HI, u_if.LO); end
      end
    end
    for (int j = 0; j < 13; j++) begin
      step(1'b0, j == 0, 3'd3, 32'h0000_0055, 32'd0, 1'b0);
      if (u_if.busy === 1'b1) nb++;
    end
    n_checks++; if (nb != DC) begin n_errors++; $display("FAIL div0_busy_len: got %0d want %0d", nb, DC); end
    n_checks++; if ({u_if.HI, u_if.LO} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_errors++; $display("FAIL div0_unchanged: got %h_%h want ffffffff_fffffffd", u_if.HI, u_if.LO); end
  endtask

  task automatic test_mthi_mtlo();
    step(1'b0, 1'b1, 3'd5, 32'h0000_1234, 32'd0, 1'b1);
    n_checks++; if (obs_stall !== 1'b0) begin n_errors++; $display("FAIL mthi_stall: got %b want 0", obs_stall); end
    n_checks++; if (u_if.HI !== 32'h0000_1234 || u_if.busy !== 1'b0) begin n_errors++; $display("FAIL mthi: got hi=%h busy=%b want 00001234 0", u_if.HI, u_if.busy); end
    step(1'b0, 1'b1, 3'd6, 32'h0000_5678, 32'd0, 1'b1);
    n_checks++; if (obs_stall !== 1'b0) begin n_errors++; $display("FAIL mtlo_stall: got %b want 0", obs_stall); end
    n_checks++; if ({u_if.HI, u_if.LO} !== {32'h0000_1234, 32'h0000_5678} || u_if.busy !== 1'b0) begin n_errors++; $display("FAIL mtlo: got %h_%h busy=%b want 00001234_00005678 0", u_if.HI, u_if.LO, u_if.busy); end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 7; i++) step(1'b0, i == 0, 3'd4, 32'd100, 32'd7, 1'b0);
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    n_checks++; if ({u_if.busy, u_if.HI, u_if.LO} !== 65'd0) begin n_errors++; $display("FAIL abort_reset: got busy=%b %h_%h want 0", u_if.busy, u_if.HI, u_if.LO); end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    n_checks++; if ({u_if.busy, u_if.HI, u_if.LO} !== 65'd0) begin n_errors++; $display("FAIL abort_no_commit: got busy=%b %h_%h want 0", u_if.busy, u_if.HI, u_if.LO); end
  endtask

  task automatic test_busy_start();
    step(1'b0, 1'b1, 3'd1, 32'd6, 32'd7, 1'b0);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 3'd1, 32'd100, 32'd100, 1'b0);
    step(1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 3'd1, 32'd9, 32'd9, 1'b1);
    n_checks++; if (obs_stall !== 1'b1) begin n_errors++; $display("FAIL commit_edge_stall: got %b want 1", obs_stall); end
    n_checks++; if ({u_if.busy, u_if.HI, u_if.LO} !== {1'b0, 32'd0, 32'd42}) begin n_errors++; $display("FAIL busy_start_commit: got busy=%b %h_%h want 0 00000000_0000002a", u_if.busy, u_if.HI, u_if.LO); end
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    n_checks++; if ({u_if.busy, u_if.LO} !== {1'b0, 32'd42}) begin n_errors++; $display("FAIL busy_start_after: got busy=%b lo=%h want 0 0000002a", u_if.busy, u_if.LO); end
  endtask

  task automatic test_random();
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 97) == 0, ($urandom % 3) != 0, 3'($urandom % 8), pick(), pick(), ($urandom % 2) == 0);
      n_checks++; if (obs_stall !== exp_stall) begin n_errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, obs_stall, exp_stall); end
      n_checks++; if (u_if.busy !== (m_left > 0)) begin n_errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, u_if.busy, m_left > 0); end
      n_checks++; if ({u_if.HI, u_if.LO} !== {m_hi, m_lo}) begin n_errors++; $display("FAIL rnd_hilo[%0d]: got %h_%h want %h_%h", i, u_if.HI, u_if.LO, m_hi, m_lo); end
    end
  endtask

  initial begin
    reset = 1'b1; u_if.E_start = 1'b0; u_if.E_op = 3'd0;
    u_if.E_rs = 32'd0; u_if.E_rt = 32'd0; u_if.D_md_use = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_reset_abort();
    test_busy_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
